// File: rtl/bmd_wdma_pkg.sv
// Shared encodings for the write-DMA ring sequencer: one-hot FSM states,
// IRQ status codes and the per-frame address stride helper.
package bmd_wdma_pkg;

  // One-hot FSM encodings
  localparam logic [5:0] S_IDLE      = 6'b000001;
  localparam logic [5:0] S_LOAD      = 6'b000010;
  localparam logic [5:0] S_WAIT_CC   = 6'b000100;
  localparam logic [5:0] S_DOING_DMA = 6'b001000;
  localparam logic [5:0] S_CHECK     = 6'b010000;
  localparam logic [5:0] S_STOPPED   = 6'b100000;

  typedef enum logic [3:0] {
    ST_NONE        = 4'b0000,
    ST_NEXT        = 4'b0001,
    ST_EMPTY_START = 4'b0010,
    ST_DONE_EMPTY  = 4'b0011,
    ST_STOP        = 4'b0100,
    ST_TIMEOUT     = 4'b1000
  } wdma_status_e;

  // Bytes written per frame: 4 * len * count, always formed in 32 bits.
  function automatic logic [31:0] frame_stride(input logic [9:0] len, input logic [15:0] cnt);
    logic [31:0] p;
    p = 32'(len) * 32'(cnt);
    return p << 2;
  endfunction

endpackage

// File: rtl/bmd_wdma_ring_fsm_if.sv
// Link between the ring sequencer and the 64-bit MWr TLP engine.
interface bmd_wdma_ring_fsm_if #(parameter int ADDR_W = 40);
  logic [9:0]        mwr_len_i;
  logic [15:0]       mwr_count_i;
  logic              wdma_rst_o;
  logic              wdma_start_o;
  logic [ADDR_W-1:0] wdma_addr_o;
  logic              wdma_done_i;

  modport master (input  mwr_len_i, mwr_count_i, wdma_done_i,
                  output wdma_rst_o, wdma_start_o, wdma_addr_o);
  modport slave  (output mwr_len_i, mwr_count_i, wdma_done_i,
                  input  wdma_rst_o, wdma_start_o, wdma_addr_o);
endinterface

// File: rtl/bmd_desc_fifo.sv
// Small synchronous FIFO of buffer descriptors with first-word fall-through
// read data and an occupancy count.
module bmd_desc_fifo #(
  parameter int W     = 56,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk) begin
    if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/bmd_wdma_ring_fsm.sv
// Write-DMA ring sequencer: pops buffer descriptors, starts one DMA per CC
// timeframe, and reports buffer boundaries / termination through an IRQ.
module bmd_wdma_ring_fsm
  import bmd_wdma_pkg::*;
#(
  parameter int ADDR_W     = 40,
  parameter int DESC_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_rst_i,
  input  logic [ADDR_W-1:0]           desc_addr_i,
  input  logic [CNT_W-1:0]            desc_frames_i,
  input  logic                        desc_valid_i,
  output logic                        desc_ready_o,
  output logic                        desc_err_o,
  output logic [$clog2(DESC_DEPTH):0] desc_level_o,
  input  logic                        wdma_start_i,
  input  logic                        wdma_stop_i,
  output logic                        wdma_running_o,
  input  logic                        timeframe_end_rise_i,
  bmd_wdma_ring_fsm_if.master         dma,
  output logic                        wdma_irq_o,
  output logic [3:0]                  wdma_status_o,
  output logic [CNT_W-1:0]            wdma_buf_ptr_o,
  output logic [CNT_W-1:0]            wdma_buf_seq_o,
  output logic                        cc_timeout_o
);
  logic                 srst;
  logic [5:0]           state_q, state_d;
  logic                 pop, push, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]    fifo_addr;
  logic [CNT_W-1:0]     fifo_frames;
  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     frames_q, buf_ptr_q, buf_seq_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 tf_q, stop_q, start_q, running_q, irq_q, err_q;
  logic                 from_idle_q, pend_q;
  wdma_status_e         status_q, pend_code_q;
  logic                 tmo;

  assign srst = ~rst_n | init_rst_i;
  assign tmo  = tmo_q[TIMEOUT_W-1];
  assign push = desc_valid_i & desc_ready_o & (desc_frames_i != '0);

  bmd_desc_fifo #(.W(ADDR_W + CNT_W), .DEPTH(DESC_DEPTH)) u_fifo (
    .clk     (clk),
    .clr_i   (srst),
    .push_i  (push),
    .wdata_i ({desc_addr_i, desc_frames_i}),
    .pop_i   (pop),
    .rdata_o ({fifo_addr, fifo_frames}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (desc_level_o)
  );

  assign desc_ready_o     = ~fifo_full;
  assign desc_err_o       = err_q;
  assign wdma_running_o   = running_q;
  assign wdma_irq_o       = irq_q;
  assign wdma_status_o    = status_q;
  assign wdma_buf_ptr_o   = buf_ptr_q;
  assign wdma_buf_seq_o   = buf_seq_q;
  assign cc_timeout_o     = tmo;
  assign dma.wdma_start_o = start_q;
  assign dma.wdma_addr_o  = addr_q;
  assign dma.wdma_rst_o   = timeframe_end_rise_i & (state_q == S_WAIT_CC);

  // Next-state decode and descriptor pop strobe
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:      if (wdma_start_i) state_d = S_LOAD;
      S_LOAD:      if (!fifo_empty && !stop_q) begin
                     pop     = 1'b1;
                     state_d = S_WAIT_CC;
                   end else state_d = S_STOPPED;
      S_WAIT_CC:   if (tmo) state_d = S_STOPPED;
                   else if (tf_q) state_d = S_DOING_DMA;
      S_DOING_DMA: if (dma.wdma_done_i) state_d = S_CHECK;
      S_CHECK:     if (stop_q) state_d = S_STOPPED;
                   else if (buf_ptr_q == frames_q) state_d = S_LOAD;
                   else state_d = S_WAIT_CC;
      S_STOPPED:   state_d = S_STOPPED;
      default:     state_d = S_IDLE;
    endcase
  end

  // Sequencer datapath, IRQ generation and housekeeping counters
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      frames_q    <= '0;
      buf_ptr_q   <= '0;
      buf_seq_q   <= '0;
      tmo_q       <= '0;
      tf_q        <= 1'b0;
      stop_q      <= 1'b0;
      start_q     <= 1'b0;
      running_q   <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      from_idle_q <= 1'b0;
      pend_q      <= 1'b0;
      status_q    <= ST_NONE;
      pend_code_q <= ST_NONE;
    end else begin
      state_q <= state_d;
      irq_q   <= 1'b0;
      tf_q    <= timeframe_end_rise_i;
      err_q   <= desc_valid_i && (desc_frames_i == '0);

      if (wdma_start_i || timeframe_end_rise_i) tmo_q <= '0;
      else if (!tmo)                            tmo_q <= tmo_q + 1'b1;

      if (state_d == S_STOPPED && state_q != S_STOPPED) stop_q <= 1'b0;
      else if (wdma_stop_i)                            stop_q <= 1'b1;

      case (state_q)
        S_IDLE: from_idle_q <= 1'b1;
        S_LOAD: begin
          buf_ptr_q   <= '0;
          from_idle_q <= 1'b0;
          if (pop) begin
            addr_q    <= fifo_addr;
            frames_q  <= fifo_frames;
            running_q <= 1'b1;
          end else begin
            // A buffer-boundary IRQ just went out in this cycle when we came
            // from CHECK, so the termination IRQ is deferred to STOPPED.
            running_q   <= 1'b0;
            pend_q      <= stop_q | from_idle_q;
            pend_code_q <= stop_q ? ST_STOP : ST_EMPTY_START;
          end
        end
        S_WAIT_CC: begin
          if (tmo) begin
            running_q <= 1'b0;
            irq_q     <= 1'b1;
            status_q  <= ST_TIMEOUT;
          end else if (tf_q) start_q <= 1'b1;
        end
        S_DOING_DMA: begin
          if (dma.wdma_done_i) begin
            start_q   <= 1'b0;
            addr_q    <= addr_q + ADDR_W'(frame_stride(dma.mwr_len_i, dma.mwr_count_i));
            buf_ptr_q <= buf_ptr_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (stop_q) begin
            running_q <= 1'b0;
            irq_q     <= 1'b1;
            status_q  <= ST_STOP;
          end else if (buf_ptr_q == frames_q) begin
            irq_q     <= 1'b1;
            buf_seq_q <= buf_seq_q + 1'b1;
            status_q  <= fifo_empty ? ST_DONE_EMPTY : ST_NEXT;
          end
        end
        S_STOPPED: begin
          running_q <= 1'b0;
          if (pend_q) begin
            pend_q   <= 1'b0;
            irq_q    <= 1'b1;
            status_q <= pend_code_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bmd_wdma_ring_fsm.sv
// Directed bench for the write-DMA ring sequencer: descriptor queue vectors
// from a table, then hand-written multi-cycle scenarios.
module tb_bmd_wdma_ring_fsm;
  localparam int ADDR_W = 40;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n, init_rst_i;
  logic [ADDR_W-1:0] desc_addr_i;
  logic [CNT_W-1:0]  desc_frames_i;
  logic              desc_valid_i, desc_ready_o, desc_err_o;
  logic [2:0]        desc_level_o;
  logic              wdma_start_i, wdma_stop_i, wdma_running_o, timeframe_end_rise_i;
  logic              wdma_irq_o, cc_timeout_o;
  logic [3:0]        wdma_status_o;
  logic [CNT_W-1:0]  wdma_buf_ptr_o, wdma_buf_seq_o;

  bmd_wdma_ring_fsm_if #(.ADDR_W(ADDR_W)) dma_if ();

  bmd_wdma_ring_fsm #(.ADDR_W(ADDR_W), .DESC_DEPTH(4), .CNT_W(CNT_W), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .init_rst_i(init_rst_i),
    .desc_addr_i(desc_addr_i), .desc_frames_i(desc_frames_i), .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o), .desc_err_o(desc_err_o), .desc_level_o(desc_level_o),
    .wdma_start_i(wdma_start_i), .wdma_stop_i(wdma_stop_i), .wdma_running_o(wdma_running_o),
    .timeframe_end_rise_i(timeframe_end_rise_i), .dma(dma_if),
    .wdma_irq_o(wdma_irq_o), .wdma_status_o(wdma_status_o),
    .wdma_buf_ptr_o(wdma_buf_ptr_o), .wdma_buf_seq_o(wdma_buf_seq_o),
    .cc_timeout_o(cc_timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0;
  int b2b     = 0;
  logic irq_prev = 1'b0;

  // IRQ bookkeeping sampled mid-cycle
  always @(negedge clk) begin
    if (wdma_irq_o) begin
      irq_cnt++;
      if (irq_prev) b2b++;
    end
    irq_prev = wdma_irq_o;
  end

  typedef struct {
    logic        vld;
    logic [39:0] addr;
    logic [15:0] frames;
    logic [2:0]  lvl;
    logic        rdy;
    logic        err;
  } qvec_t;

  qvec_t tbl [8];

  localparam logic [39:0] A_ADDR = 40'h10_0000_0000;
  localparam logic [39:0] B_ADDR = 40'h20_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [39:0] a, input logic [15:0] f);
    desc_addr_i = a; desc_frames_i = f; desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
  endtask

  task automatic start_cmd();
    wdma_start_i = 1'b1;
    step();
    wdma_start_i = 1'b0;
    step();
  endtask

  task automatic pulse_tf(input logic exp_rst);
    timeframe_end_rise_i = 1'b1;
    #1;
    chk("wdma_rst", dma_if.wdma_rst_o, exp_rst);
    step();
    timeframe_end_rise_i = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!dma_if.wdma_start_o && k < 20) begin step(); k++; end
    chk("start_seen", dma_if.wdma_start_o, 1);
  endtask

  task automatic do_done();
    dma_if.wdma_done_i = 1'b1;
    step();
    dma_if.wdma_done_i = 1'b0;
  endtask

  task automatic wait_irq(input int n, output logic [3:0] st);
    int k = 0;
    while (!wdma_irq_o && k < n) begin step(); k++; end
    chk("irq_seen", wdma_irq_o, 1);
    st = wdma_status_o;
  endtask

  initial begin
    logic [3:0] st;
    int base;

    rst_n = 1'b1; init_rst_i = 1'b0;
    desc_addr_i = '0; desc_frames_i = '0; desc_valid_i = 1'b0;
    wdma_start_i = 1'b0; wdma_stop_i = 1'b0; timeframe_end_rise_i = 1'b0;
    dma_if.mwr_len_i = 10'd32; dma_if.mwr_count_i = 16'd16; dma_if.wdma_done_i = 1'b0;

    tbl[0] = '{1'b1, 40'h1_0000, 16'd1, 3'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 40'h2_0000, 16'd0, 3'd1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 40'h0,      16'd0, 3'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 40'h3_0000, 16'd2, 3'd2, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 40'h4_0000, 16'd3, 3'd3, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 40'h5_0000, 16'd4, 3'd4, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 40'h6_0000, 16'd5, 3'd4, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 40'h0,      16'd0, 3'd4, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_level", desc_level_o, 0);
    chk("rst_ready", desc_ready_o, 1);
    chk("rst_err", desc_err_o, 0);
    chk("rst_running", wdma_running_o, 0);
    chk("rst_start", dma_if.wdma_start_o, 0);
    chk("rst_addr", dma_if.wdma_addr_o, 0);
    chk("rst_irq", wdma_irq_o, 0);
    chk("rst_status", wdma_status_o, 0);
    chk("rst_timeout", cc_timeout_o, 0);
    chk("rst_seq", wdma_buf_seq_o, 0);

    // Descriptor queue vectors
    for (int i = 0; i < 8; i++) begin
      desc_addr_i = tbl[i].addr; desc_frames_i = tbl[i].frames; desc_valid_i = tbl[i].vld;
      step();
      desc_valid_i = 1'b0;
      chk($sformatf("q%0d_level", i), desc_level_o, tbl[i].lvl);
      chk($sformatf("q%0d_ready", i), desc_ready_o, tbl[i].rdy);
      chk($sformatf("q%0d_err", i), desc_err_o, tbl[i].err);
    end

    // Two buffers streamed back to back
    do_reset();
    push(A_ADDR, 16'd2);
    push(B_ADDR, 16'd1);
    chk("s1_level", desc_level_o, 2);
    base = irq_cnt;
    start_cmd();
    chk("s1_running", wdma_running_o, 1);
    chk("s1_level_pop", desc_level_o, 1);
    pulse_tf(1'b1);
    wait_start();
    chk("s1_addr0", dma_if.wdma_addr_o, A_ADDR);
    do_done();
    chk("s1_start_drop", dma_if.wdma_start_o, 0);
    chk("s1_ptr1", wdma_buf_ptr_o, 1);
    step();
    pulse_tf(1'b1);
    wait_start();
    chk("s1_addr1", dma_if.wdma_addr_o, A_ADDR + 40'h800);
    do_done();
    wait_irq(10, st);
    chk("s1_status_next", st, 4'b0001);
    chk("s1_seq1", wdma_buf_seq_o, 1);
    step();
    pulse_tf(1'b1);
    wait_start();
    chk("s1_addr2", dma_if.wdma_addr_o, B_ADDR);
    chk("s1_ptr0", wdma_buf_ptr_o, 0);
    do_done();
    wait_irq(10, st);
    chk("s1_status_done", st, 4'b0011);
    chk("s1_seq2", wdma_buf_seq_o, 2);
    repeat (5) step();
    chk("s1_stopped", wdma_running_o, 0);
    chk("s1_irqs", irq_cnt - base, 2);
    pulse_tf(1'b0);
    repeat (3) step();
    chk("s1_no_start", dma_if.wdma_start_o, 0);

    // Start with an empty queue
    init_rst_i = 1'b1; step(); init_rst_i = 1'b0;
    base = irq_cnt;
    start_cmd();
    wait_irq(10, st);
    chk("s2_status", st, 4'b0010);
    chk("s2_running", wdma_running_o, 0);
    repeat (5) step();
    chk("s2_irqs", irq_cnt - base, 1);

    // CC timeout while waiting for a timeframe
    do_reset();
    push(A_ADDR, 16'd1);
    start_cmd();
    repeat (30000) step();
    chk("s3_timeout_early", cc_timeout_o, 0);
    wait_irq(4000, st);
    chk("s3_status", st, 4'b1000);
    chk("s3_timeout", cc_timeout_o, 1);
    step();
    chk("s3_running", wdma_running_o, 0);

    // Stop request during a frame
    do_reset();
    push(A_ADDR, 16'd2);
    base = irq_cnt;
    start_cmd();
    pulse_tf(1'b1);
    wait_start();
    wdma_stop_i = 1'b1; step(); wdma_stop_i = 1'b0;
    chk("s4_start_held", dma_if.wdma_start_o, 1);
    do_done();
    wait_irq(10, st);
    chk("s4_status", st, 4'b0100);
    chk("s4_addr", dma_if.wdma_addr_o, A_ADDR + 40'h800);
    step();
    chk("s4_running", wdma_running_o, 0);
    pulse_tf(1'b0);
    repeat (4) step();
    chk("s4_no_start", dma_if.wdma_start_o, 0);
    chk("s4_irqs", irq_cnt - base, 1);

    // Soft reset mid-frame with a concurrent push
    do_reset();
    push(A_ADDR, 16'd2);
    push(B_ADDR, 16'd1);
    start_cmd();
    pulse_tf(1'b1);
    wait_start();
    init_rst_i = 1'b1;
    desc_addr_i = B_ADDR; desc_frames_i = 16'd3; desc_valid_i = 1'b1;
    step();
    init_rst_i = 1'b0; desc_valid_i = 1'b0;
    chk("s5_level", desc_level_o, 0);
    chk("s5_start", dma_if.wdma_start_o, 0);
    chk("s5_addr", dma_if.wdma_addr_o, 0);
    chk("s5_running", wdma_running_o, 0);
    chk("s5_ready", desc_ready_o, 1);
    chk("s5_ptr", wdma_buf_ptr_o, 0);
    chk("s5_status", wdma_status_o, 0);
    pulse_tf(1'b0);

    chk("irq_back_to_back", b2b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmd_wdma_ring_fsm.md
Name: bmd_wdma_ring_fsm

Overview:
Parametrised write-DMA sequencer that streams communication-controller (CC) frames into a ring of host buffers. Buffer descriptors (address, frame count) are held in an on-chip queue of depth DESC_DEPTH, so host software can stay several buffers ahead of the hardware. The block sits between the register/control interface and the 64-bit MWr TLP engine. For each CC timeframe end it issues one DMA start per frame, raises an IRQ with a status code at every buffer boundary, and raises an IRQ on stop or on CC timeout.

Parameters:
ADDR_W, 40, host address width (32..64)
DESC_DEPTH, 4, descriptor queue depth (power of 2, >=2)
CNT_W, 16, width of frame counters and buffer pointer
TIMEOUT_W, 16, CC timeout counter width; timeout fires when counter MSB is set (2^(TIMEOUT_W-1) cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
init_rst_i  in  1  soft reset, synchronous, same effect as rst_n
mwr_len_i  in  10  TLP payload length in DWORDs
mwr_count_i  in  16  TLPs per frame
desc_addr_i  in  ADDR_W  buffer base address to enqueue
desc_frames_i  in  CNT_W  frames in this buffer
desc_valid_i  in  1  enqueue request
desc_ready_o  out  1  queue not full
desc_err_o  out  1  one-cycle pulse: descriptor with zero frames rejected
desc_level_o  out  $clog2(DESC_DEPTH)+1  queued descriptors
wdma_start_i  in  1  run command (level, sampled in IDLE)
wdma_stop_i  in  1  stop request pulse
wdma_running_o  out  1  a buffer is active
timeframe_end_rise_i  in  1  CC frame-ready pulse
wdma_rst_o  out  1  TLP engine reset: timeframe_end_rise_i AND state==WAIT_CC (combinational)
wdma_start_o  out  1  DMA engine start (level until done)
wdma_addr_o  out  ADDR_W  current frame destination address
wdma_done_i  in  1  DMA engine frame complete
wdma_irq_o  out  1  one-cycle IRQ pulse
wdma_status_o  out  4  status code, valid from the IRQ cycle until the next IRQ
wdma_buf_ptr_o  out  CNT_W  frames completed in current buffer
wdma_buf_seq_o  out  CNT_W  buffers completed since start (wraps)
cc_timeout_o  out  1  timeout counter MSB

Behaviour:
- Reset (rst_n low or init_rst_i high at posedge): state IDLE, queue empty, all outputs 0, desc_ready_o=1, stop latch and timeout counter cleared. init_rst_i overrides any concurrent push or transition.
- Queue: push when desc_valid_i & desc_ready_o & desc_frames_i!=0. Zero frames: nothing written, desc_err_o pulses. Push while full is dropped with no error. A push and pop in the same cycle are both honoured and the level is unchanged.
- Timeout counter: cleared on init_rst_i, wdma_start_i or timeframe_end_rise_i; otherwise increments and saturates at MSB set.
- timeframe_end_rise_i is registered once; the FSM acts on the registered copy (1-cycle latency).
- Stop latch: set by wdma_stop_i, cleared on entry to STOPPED. A stop during DOING_DMA lets the current frame finish.
- FSM (one-hot):
  - IDLE: if wdma_start_i -> LOAD.
  - LOAD: buf_ptr<=0. If queue non-empty and no stop: pop; addr<=desc_addr; frames_left<=desc_frames; running=1; -> WAIT_CC. Otherwise -> STOPPED.
  - WAIT_CC: on timeout -> STOPPED, IRQ, status 1000. On registered timeframe rise: start_o=1 -> DOING_DMA.
  - DOING_DMA: on wdma_done_i: start_o=0; addr<=addr+4*mwr_len*mwr_count, computed in 32 bits, zero-extended, wraps modulo 2^ADDR_W; buf_ptr++ -> CHECK.
  - CHECK: if stop -> STOPPED, IRQ, status 0100. Else if buf_ptr==frames: IRQ; buf_seq++; status 0001 if queue non-empty, else 0011; -> LOAD. Else -> WAIT_CC.
  - STOPPED: running=0; stays until init_rst_i. If entered from LOAD with an empty queue and no prior CHECK IRQ, IRQ with status 0010. Stop latch set in LOAD: IRQ with status 0100.
- Exactly one IRQ per buffer boundary or termination; never two IRQs in consecutive cycles.

Decomposition:
- Package bmd_wdma_pkg: state encodings, status codes (ST_NEXT=0001, ST_EMPTY_START=0010, ST_DONE_EMPTY=0011, ST_STOP=0100, ST_TIMEOUT=1000).
- Sub-module bmd_desc_fifo: synchronous FIFO of {addr, frames}, width ADDR_W+CNT_W, depth DESC_DEPTH, with level output.

Test Plan:
- Push 2 descriptors (0x10_0000_0000 with 2 frames, 0x20_0000_0000 with 1 frame), mwr_len=32, mwr_count=16, start, 3 timeframes -> addresses 0x10_0000_0000, 0x10_0000_0800, 0x20_0000_0000; IRQ status 0001, then 0011; buf_seq=2; then STOPPED.
- Start with empty queue -> one IRQ with status 0010; running stays 0.
- No timeframe for 2^15 cycles in WAIT_CC -> cc_timeout_o=1, IRQ with status 1000, running=0.
- wdma_stop_i mid-DOING_DMA -> frame completes, addr advances, IRQ with status 0100, no further start.
- Fill queue to DESC_DEPTH, push again, and push frames=0 -> ready=0 and drop; desc_err_o pulse; level=DESC_DEPTH.
- init_rst_i during DOING_DMA with simultaneous push -> all outputs 0, level 0, IDLE.
